turret_bullet_ctrl: RTL and testbench

Projectile engine fed by the turret-angle controller. It latches the turret's current bullet launch position and per-frame motion vector on a fire-key press, then advances the bullet once per video frame. It reports a hit against a rectangular target box, or a miss when the bullet leaves the screen. It sits between the keyboard/turret logic and the sprite renderer, which draws the bullet from `bullet_x`/`bullet_y` while `bullet_active` is high.

---
 rtl/bullet_pkg.sv | 19 +
 rtl/turret_bullet_ctrl_key_edge_det.sv | 23 ++
 rtl/turret_bullet_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_turret_bullet_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and constants for the turret bullet engine.
package bullet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLY,
    ST_COOLDOWN
  } bullet_state_t;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  localparam logic [7:0] KEY_FIRE = 8'h2C;
  localparam logic [7:0] KEY_UP   = 8'h1A;
  localparam logic [7:0] KEY_DOWN = 8'h16;

  localparam logic signed [9:0] GRAVITY_VY_MAX = 10'sd15;

endpackage

// File: rtl/turret_bullet_ctrl_key_edge_det.sv
// Press detector: pulses while the watched key is present now but was not
// present on the previous cycle, so holding a key yields a single pulse.
module key_edge_det
  import bullet_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_FIRE
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press
);

  logic [7:0] r_prev_key;

  always_ff @(posedge clk2) begin
    if (!Reset) r_prev_key <= '0;
    else        r_prev_key <= keycode;
  end

  assign press = (keycode == KEY) && (r_prev_key != KEY);

endmodule

// File: rtl/turret_bullet_ctrl.sv
// Projectile engine: latches launch state on a fire press, steps the bullet
// once per frame and reports hit/miss. Optional gravity: BULLET_GRAVITY_EN.
module turret_bullet_ctrl
  import bullet_pkg::*;
#(
  parameter logic [7:0]  FIRE_KEY        = KEY_FIRE,
  parameter int unsigned SCREEN_W        = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H        = SCREEN_H_DEF,
  parameter int unsigned SPEED_SHIFT     = 2,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic [9:0] motion_x,
  input  logic [9:0] motion_y,
  input  logic [9:0] init_x,
  input  logic [9:0] init_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  logic [9:0] target_w,
  input  logic [9:0] target_h,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] shots_fired
);

  localparam int unsigned CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [11:0] SCR_W = 12'(SCREEN_W);
  localparam logic signed [11:0] SCR_H = 12'(SCREEN_H);

  bullet_state_t r_state, w_state_nxt;

  logic [9:0]    r_bx, r_by, w_bx_nxt, w_by_nxt;
  logic [9:0]    r_vx, r_vy, w_vx_nxt, w_vy_nxt;
  logic [CW-1:0] r_cool, w_cool_nxt;
  logic [7:0]    r_shots, w_shots_nxt;
  logic          r_hit, r_miss, w_hit_nxt, w_miss_nxt;

  logic                w_fire;
  logic signed [11:0]  w_nx, w_ny;
  logic [10:0]         w_tx_end, w_ty_end;
  logic                w_hit, w_oob;

`ifdef BULLET_GRAVITY_EN
  logic [1:0] r_gcnt, w_gcnt_nxt;
`endif

  key_edge_det #(
    .KEY (FIRE_KEY)
  ) u_fire_edge (
    .clk2    (clk2),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (w_fire)
  );

  // Position zero-extended, velocity sign-extended, both into 12-bit signed.
  assign w_nx = $signed({2'b00, r_bx}) + ($signed({{2{r_vx[9]}}, r_vx}) <<< SPEED_SHIFT);
  assign w_ny = $signed({2'b00, r_by}) + ($signed({{2{r_vy[9]}}, r_vy}) <<< SPEED_SHIFT);

  assign w_tx_end = {1'b0, target_x} + {1'b0, target_w};
  assign w_ty_end = {1'b0, target_y} + {1'b0, target_h};

  assign w_hit = !w_nx[11] && !w_ny[11] &&
                 (w_nx[10:0] >= {1'b0, target_x}) && (w_nx[10:0] < w_tx_end) &&
                 (w_ny[10:0] >= {1'b0, target_y}) && (w_ny[10:0] < w_ty_end);

  assign w_oob = w_nx[11] || (w_nx >= SCR_W) || w_ny[11] || (w_ny >= SCR_H);

  always_ff @(posedge clk2) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_bx;
    w_by_nxt    = r_by;
    w_vx_nxt    = r_vx;
    w_vy_nxt    = r_vy;
    w_cool_nxt  = r_cool;
    w_shots_nxt = r_shots;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
`ifdef BULLET_GRAVITY_EN
    w_gcnt_nxt  = r_gcnt;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_state_nxt = ST_FLY;
          w_bx_nxt    = init_x;
          w_by_nxt    = init_y;
          w_vx_nxt    = motion_x;
          w_vy_nxt    = motion_y;
          w_shots_nxt = r_shots + 8'd1;
`ifdef BULLET_GRAVITY_EN
          w_gcnt_nxt  = '0;
`endif
        end
      end

      ST_FLY: begin
        if (frame_tick) begin
`ifdef BULLET_GRAVITY_EN
          // The move below already used the old vy; the kick applies next tick.
          w_gcnt_nxt = r_gcnt + 2'd1;
          if ((r_gcnt == 2'd3) && ($signed(r_vy) < GRAVITY_VY_MAX))
            w_vy_nxt = r_vy + 10'd1;
`endif
          if (w_hit) begin
            w_hit_nxt   = 1'b1;
            w_state_nxt = ST_COOLDOWN;
            w_cool_nxt  = CW'(COOLDOWN_FRAMES);
          end else if (w_oob) begin
            w_miss_nxt  = 1'b1;
            w_state_nxt = ST_COOLDOWN;
            w_cool_nxt  = CW'(COOLDOWN_FRAMES);
          end else begin
            w_bx_nxt = w_nx[9:0];
            w_by_nxt = w_ny[9:0];
          end
        end
      end

      ST_COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) begin
          w_state_nxt = ST_IDLE;
        end else if (frame_tick) begin
          if (r_cool == '0) w_state_nxt = ST_IDLE;
          else              w_cool_nxt  = r_cool - CW'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (!Reset) begin
      r_bx    <= '0;
      r_by    <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_cool  <= '0;
      r_shots <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
`ifdef BULLET_GRAVITY_EN
      r_gcnt  <= '0;
`endif
    end else begin
      r_bx    <= w_bx_nxt;
      r_by    <= w_by_nxt;
      r_vx    <= w_vx_nxt;
      r_vy    <= w_vy_nxt;
      r_cool  <= w_cool_nxt;
      r_shots <= w_shots_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
`ifdef BULLET_GRAVITY_EN
      r_gcnt  <= w_gcnt_nxt;
`endif
    end
  end

  assign bullet_active = (r_state == ST_FLY);
  assign bullet_x      = r_bx;
  assign bullet_y      = r_by;
  assign hit_pulse     = r_hit;
  assign miss_pulse    = r_miss;
  assign shots_fired   = r_shots;

endmodule

// File: tb/tb_turret_bullet_ctrl.sv
// Self-checking bench for turret_bullet_ctrl: directed scenarios plus
// randomized shots checked against an integer-arithmetic flight model.
module tb_turret_bullet_ctrl;

  logic       clk2 = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [9:0] motion_x, motion_y, init_x, init_y;
  logic [9:0] target_x, target_y, target_w, target_h;
  logic       bullet_active, hit_pulse, miss_pulse;
  logic [9:0] bullet_x, bullet_y;
  logic [7:0] shots_fired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk2 = ~clk2;

  turret_bullet_ctrl #(
    .FIRE_KEY        (8'h2C),
    .SCREEN_W        (640),
    .SCREEN_H        (480),
    .SPEED_SHIFT     (2),
    .COOLDOWN_FRAMES (8)
  ) dut (
    .clk2          (clk2),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .motion_x      (motion_x),
    .motion_y      (motion_y),
    .init_x        (init_x),
    .init_y        (init_y),
    .target_x      (target_x),
    .target_y      (target_y),
    .target_w      (target_w),
    .target_h      (target_h),
    .bullet_active (bullet_active),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .shots_fired   (shots_fired)
  );

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic tap();
    keycode = 8'h2C;
    cyc();
    keycode = 8'h00;
  endtask

  task automatic do_reset();
    Reset = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
    cyc(); cyc();
    Reset = 1'b1;
  endtask

  task automatic set_shot(input int ix, input int iy, input int mx, input int my);
    init_x = 10'(ix); init_y = 10'(iy); motion_x = 10'(mx); motion_y = 10'(my);
  endtask

  task automatic set_target(input int tx, input int ty, input int tw, input int th);
    target_x = 10'(tx); target_y = 10'(ty); target_w = 10'(tw); target_h = 10'(th);
  endtask

  task automatic test_reset();
    set_shot(123, 45, 3, 7);
    set_target(0, 0, 0, 0);
    Reset = 1'b0; keycode = 8'h2C; frame_tick = 1'b1;
    cyc();
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y, hit_pulse, miss_pulse, shots_fired} !== '0)
      $display("FAIL reset_outputs: got a=%b x=%0d y=%0d h=%b m=%b s=%0d, want all zero",
               bullet_active, bullet_x, bullet_y, hit_pulse, miss_pulse, shots_fired);
    else n_pass++;
    keycode = 8'h00; frame_tick = 1'b0;
    cyc();
    Reset = 1'b1;
    cyc();
    n_checks++;
    if ({bullet_active, shots_fired} !== 9'd0)
      $display("FAIL reset_release_idle: got a=%b s=%0d, want 0/0", bullet_active, shots_fired);
    else n_pass++;
  endtask

  task automatic test_basic_fire();
    do_reset();
    set_shot(85, 40, 1, 0);
    set_target(0, 0, 0, 0);
    tap();
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y, shots_fired} !== {1'b1, 10'd85, 10'd40, 8'd1})
      $display("FAIL fire_latch: got a=%b (%0d,%0d) s=%0d, want 1 (85,40) 1",
               bullet_active, bullet_x, bullet_y, shots_fired);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc();
    end
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y} !== {1'b1, 10'd97, 10'd40})
      $display("FAIL three_ticks: got a=%b (%0d,%0d), want 1 (97,40)",
               bullet_active, bullet_x, bullet_y);
    else n_pass++;
  endtask

  task automatic test_fire_with_tick();
    do_reset();
    set_shot(200, 200, 3, 3);
    set_target(0, 0, 0, 0);
    keycode = 8'h2C; frame_tick = 1'b1;
    cyc();
    keycode = 8'h00; frame_tick = 1'b0;
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y} !== {1'b1, 10'd200, 10'd200})
      $display("FAIL fire_tick_same_cycle: got a=%b (%0d,%0d), want 1 (200,200)",
               bullet_active, bullet_x, bullet_y);
    else n_pass++;
  endtask

  task automatic test_hold_key();
    do_reset();
    set_shot(600, 40, 1, 0);
    set_target(0, 0, 0, 0);
    keycode = 8'h2C;
    for (int i = 0; i < 100; i++) begin
      frame_tick = (i % 5 == 4);
      cyc();
    end
    frame_tick = 1'b0;
    n_checks++;
    if ({bullet_active, shots_fired} !== {1'b0, 8'd1})
      $display("FAIL hold_single_shot: got a=%b s=%0d, want 0 1", bullet_active, shots_fired);
    else n_pass++;
    keycode = 8'h00;
    cyc();
    tap();
    n_checks++;
    if ({bullet_active, shots_fired} !== {1'b1, 8'd2})
      $display("FAIL hold_then_retap: got a=%b s=%0d, want 1 2", bullet_active, shots_fired);
    else n_pass++;
  endtask

  task automatic test_miss_top();
    do_reset();
    set_shot(48, 78, 0, -1);
    set_target(0, 0, 0, 0);
    tap();
    for (int k = 1; k <= 19; k++) begin
      tick();
      n_checks++;
      if ({bullet_active, bullet_x, bullet_y} !== {1'b1, 10'd48, 10'(78 - 4 * k)})
        $display("FAIL miss_step%0d: got a=%b (%0d,%0d), want 1 (48,%0d)",
                 k, bullet_active, bullet_x, bullet_y, 78 - 4 * k);
      else n_pass++;
      cyc();
    end
    tick();
    n_checks++;
    if ({miss_pulse, hit_pulse, bullet_active, bullet_x, bullet_y} !== {3'b100, 10'd48, 10'd2})
      $display("FAIL miss_pulse: got m=%b h=%b a=%b (%0d,%0d), want 1 0 0 (48,2)",
               miss_pulse, hit_pulse, bullet_active, bullet_x, bullet_y);
    else n_pass++;
    cyc();
    n_checks++;
    if (miss_pulse !== 1'b0)
      $display("FAIL miss_pulse_width: got %b, want 0", miss_pulse);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      cyc();
    end
    tap();
    n_checks++;
    if ({bullet_active, shots_fired} !== {1'b0, 8'd1})
      $display("FAIL cooldown_blocks_fire: got a=%b s=%0d, want 0 1", bullet_active, shots_fired);
    else n_pass++;
    tick();
    cyc();
    tap();
    n_checks++;
    if ({bullet_active, shots_fired} !== {1'b1, 8'd2})
      $display("FAIL cooldown_exit: got a=%b s=%0d, want 1 2", bullet_active, shots_fired);
    else n_pass++;
  endtask

  task automatic test_hit();
    do_reset();
    set_shot(85, 40, 2, 0);
    set_target(100, 38, 10, 10);
    tap();
    tick();
    n_checks++;
    if ({hit_pulse, bullet_active, bullet_x, bullet_y} !== {2'b01, 10'd93, 10'd40})
      $display("FAIL hit_tick1: got h=%b a=%b (%0d,%0d), want 0 1 (93,40)",
               hit_pulse, bullet_active, bullet_x, bullet_y);
    else n_pass++;
    cyc();
    tick();
    n_checks++;
    if ({hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y} !== {3'b100, 10'd93, 10'd40})
      $display("FAIL hit_tick2: got h=%b m=%b a=%b (%0d,%0d), want 1 0 0 (93,40)",
               hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y);
    else n_pass++;
    cyc();
    n_checks++;
    if (hit_pulse !== 1'b0)
      $display("FAIL hit_pulse_width: got %b, want 0", hit_pulse);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_shot(300, 200, 5, -3);
    set_target(355, 160, 20, 20);
    tap();
    motion_x = 10'($urandom_range(1023));
    motion_y = 10'($urandom_range(1023));
    tick();
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y} !== {1'b1, 10'd320, 10'd188})
      $display("FAIL latched_path1: got a=%b (%0d,%0d), want 1 (320,188)",
               bullet_active, bullet_x, bullet_y);
    else n_pass++;
    motion_x = 10'($urandom_range(1023));
    tick();
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y} !== {1'b1, 10'd340, 10'd176})
      $display("FAIL latched_path2: got a=%b (%0d,%0d), want 1 (340,176)",
               bullet_active, bullet_x, bullet_y);
    else n_pass++;
    // The next tick would land inside the target; reset must swallow it.
    Reset = 1'b0; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    n_checks++;
    if ({bullet_active, bullet_x, bullet_y, hit_pulse, miss_pulse, shots_fired} !== '0)
      $display("FAIL midflight_reset: got a=%b (%0d,%0d) h=%b m=%b s=%0d, want all zero",
               bullet_active, bullet_x, bullet_y, hit_pulse, miss_pulse, shots_fired);
    else n_pass++;
    Reset = 1'b1;
    cyc();
    n_checks++;
    if ({bullet_active, hit_pulse, miss_pulse} !== 3'b000)
      $display("FAIL midflight_reset_after: got a=%b h=%b m=%b, want 000",
               bullet_active, hit_pulse, miss_pulse);
    else n_pass++;
  endtask

  task automatic test_random();
    int ex, ey, vx, vy, tx, ty, tw, th, nx, ny, shots, ticks;
    bit resolved, exp_hit, exp_miss;
    do_reset();
    shots = 0;
    for (int s = 0; s < 12; s++) begin
      ex = $urandom_range(639); ey = $urandom_range(479);
      vx = int'($urandom_range(16)) - 8; vy = int'($urandom_range(16)) - 8;
      if (vx == 0) vx = 1;
      tx = $urandom_range(639); ty = $urandom_range(479);
      tw = $urandom_range(200); th = $urandom_range(200);
      set_shot(ex, ey, vx, vy);
      set_target(tx, ty, tw, th);
      keycode = 8'h2C; frame_tick = 1'($urandom_range(1));
      cyc();
      keycode = 8'h00; frame_tick = 1'b0;
      shots = (shots + 1) % 256;
      n_checks++;
      if ({bullet_active, bullet_x, bullet_y, shots_fired} !== {1'b1, 10'(ex), 10'(ey), 8'(shots)})
        $display("FAIL rnd_fire%0d: got a=%b (%0d,%0d) s=%0d, want 1 (%0d,%0d) %0d",
                 s, bullet_active, bullet_x, bullet_y, shots_fired, ex, ey, shots);
      else n_pass++;
      resolved = 0;
      ticks = 0;
      while (!resolved && ticks < 400) begin
        if ($urandom_range(3) == 0) begin
          keycode = 8'h2C; cyc(); keycode = 8'h00; cyc();
        end
        motion_x = 10'($urandom_range(1023));
        for (int g = 0; g < int'($urandom_range(2)); g++) cyc();
        nx = ex + vx * 4; ny = ey + vy * 4;
        exp_hit  = (nx >= tx) && (nx < tx + tw) && (ny >= ty) && (ny < ty + th);
        exp_miss = !exp_hit && (nx < 0 || nx >= 640 || ny < 0 || ny >= 480);
        if (!exp_hit && !exp_miss) begin ex = nx; ey = ny; end
        resolved = exp_hit || exp_miss;
        tick();
        ticks++;
        n_checks++;
        if ({hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y, shots_fired} !==
            {exp_hit, exp_miss, !resolved, 10'(ex), 10'(ey), 8'(shots)})
          $display("FAIL rnd_step%0d_%0d: got h=%b m=%b a=%b (%0d,%0d) s=%0d, want h=%b m=%b a=%b (%0d,%0d) s=%0d",
                   s, ticks, hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y, shots_fired,
                   exp_hit, exp_miss, !resolved, ex, ey, shots);
        else n_pass++;
      end
      if (!resolved) begin
        n_checks++;
        $display("FAIL rnd_unresolved%0d: got no hit/miss after %0d ticks, want resolution", s, ticks);
      end
      for (int c = 0; c < 9; c++) begin
        cyc();
        tick();
      end
      n_checks++;
      if ({hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y} !== {3'b000, 10'(ex), 10'(ey)})
        $display("FAIL rnd_cooldown%0d: got h=%b m=%b a=%b (%0d,%0d), want 000 (%0d,%0d)",
                 s, hit_pulse, miss_pulse, bullet_active, bullet_x, bullet_y, ex, ey);
      else n_pass++;
      cyc();
    end
  endtask

`ifdef BULLET_GRAVITY_EN
  task automatic test_gravity();
    do_reset();
    set_shot(100, 100, 1, 0);
    set_target(0, 0, 0, 0);
    tap();
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if ({bullet_x, bullet_y} !== {10'(100 + 4 * k), 10'((k == 5) ? 104 : 100)})
        $display("FAIL gravity_tick%0d: got (%0d,%0d), want (%0d,%0d)",
                 k, bullet_x, bullet_y, 100 + 4 * k, (k == 5) ? 104 : 100);
      else n_pass++;
      cyc();
    end
  endtask
`endif

  initial begin
    Reset = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
    set_shot(0, 0, 0, 0);
    set_target(0, 0, 0, 0);
    test_reset();
    test_basic_fire();
    test_fire_with_tick();
    test_hold_key();
    test_miss_top();
    test_hit();
    test_reset_midflight();
    test_random();
`ifdef BULLET_GRAVITY_EN
    test_gravity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
